mist_video_out: RTL and testbench

- Parametrised video output stage for MiST cores, placed between native core video and the VGA pins, ahead of or instead of the scandoubler/OSD path.
- Generalises colour depth in and out and the pixel clock-enable divider.
- Adds automatic sync polarity detection and normalisation, line-parity scanline dimming, and a fixed-latency registered output with sync matched to colour.

---
 rtl/mist_video_out.sv | 186 ++++++++++++++++++
 tb/tb_mist_video_out.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mist_video_out.sv
// mist_video_out: video output stage between a MiST core and the VGA pins.
//   - Detects the polarity of HSync/VSync and normalises both to active-low.
//   - Generates a pixel clock enable (/1,/2,/4,/8) phase-locked to line start.
//   - Expands IN_DEPTH colour to OUT_DEPTH by MSB-first bit replication.
//   - Dims odd lines (scanlines) and optionally emits composite sync.
//   - Colour and syncs share a fixed two-register latency.
// Ports:
//   clk_sys, reset_n            clock, async active-low reset
//   ce_div[1:0]                 pixel CE divider select
//   scanlines[1:0]              odd-line dimming: none/25%/50%/75%
//   csync_en                    composite sync on VGA_HS, VGA_VS held 1
//   R,G,B[IN_DEPTH-1:0]         core colour
//   HSync, VSync                core syncs, either polarity
//   VGA_R/G/B[OUT_DEPTH-1:0]    output colour
//   VGA_HS, VGA_VS              active-low output syncs
//   ce_pix                      pixel clock enable
//   hs_pol, vs_pol              detected polarity, 1 = active-high pulse

// Sync polarity detector: registers the sync and compares high/low time.
module mist_vo_poldet #(
   parameter int CNT_W = 12
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sync_i,
   output logic sync_r_o,
   output logic pol_o
);
   localparam logic [CNT_W-1:0] CMAX = '1;

   logic             sync_q, pol_q, armed_q;
   logic [CNT_W-1:0] hi_q, lo_q;
   logic             rise;

   // Rising edge seen as the registered copy takes the new level.
   assign rise     = sync_i & ~sync_q;
   assign sync_r_o = sync_q;
   assign pol_o    = pol_q;

   // Counting starts only at the first rising edge, so the first edge never
   // updates the polarity; the first complete period latches it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= 1'b1;
         pol_q   <= 1'b0;
         armed_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         sync_q <= sync_i;
         if (rise) begin
            armed_q <= 1'b1;
            if (hi_q != '0 && lo_q != '0) pol_q <= (hi_q < lo_q);
            hi_q <= '0;
            lo_q <= '0;
         end else if (armed_q) begin
            if (sync_q) begin
               if (hi_q != CMAX) hi_q <= hi_q + 1'b1;
            end else begin
               if (lo_q != CMAX) lo_q <= lo_q + 1'b1;
            end
         end
      end
   end
endmodule

module mist_video_out #(
   parameter int IN_DEPTH  = 6,
   parameter int OUT_DEPTH = 6,
   parameter int HCNT_W    = 12,
   parameter int VCNT_W    = 22
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   input  logic [1:0]           ce_div,
   input  logic [1:0]           scanlines,
   input  logic                 csync_en,
   input  logic [IN_DEPTH-1:0]  R,
   input  logic [IN_DEPTH-1:0]  G,
   input  logic [IN_DEPTH-1:0]  B,
   input  logic                 HSync,
   input  logic                 VSync,
   output logic [OUT_DEPTH-1:0] VGA_R,
   output logic [OUT_DEPTH-1:0] VGA_G,
   output logic [OUT_DEPTH-1:0] VGA_B,
   output logic                 VGA_HS,
   output logic                 VGA_VS,
   output logic                 ce_pix,
   output logic                 hs_pol,
   output logic                 vs_pol
);
   // Fill OUT_DEPTH bits by repeating the input from its MSB downwards.
   function automatic logic [OUT_DEPTH-1:0] expand(input logic [IN_DEPTH-1:0] c);
      logic [OUT_DEPTH-1:0] e;
      e = '0;
      for (int i = 0; i < OUT_DEPTH; i++) e[OUT_DEPTH-1-i] = c[IN_DEPTH-1-(i % IN_DEPTH)];
      return e;
   endfunction

   function automatic logic [OUT_DEPTH-1:0] dim(input logic [OUT_DEPTH-1:0] c,
                                               input logic [1:0] sl, input logic odd);
      logic [OUT_DEPTH-1:0] d;
      d = c;
      if (odd) begin
         case (sl)
            2'b01:   d = c - (c >> 2);
            2'b10:   d = c >> 1;
            2'b11:   d = c >> 2;
            default: d = c;
         endcase
      end
      return d;
   endfunction

   logic                hs_r, vs_r, hs_n, vs_n;
   logic                hs_n_q, vs_n_q, hs_fall, vs_fall;
   logic [IN_DEPTH-1:0] r_q, g_q, b_q;
   logic [2:0]          div_q, div_d, mask;
   logic                par_q, par_d, ce_q;
   logic [OUT_DEPTH-1:0] vr_q, vg_q, vb_q;
   logic                vhs_q, vvs_q;

   mist_vo_poldet #(.CNT_W(HCNT_W)) u_hdet (
      .clk_i(clk_sys), .rst_ni(reset_n), .sync_i(HSync), .sync_r_o(hs_r), .pol_o(hs_pol));
   mist_vo_poldet #(.CNT_W(VCNT_W)) u_vdet (
      .clk_i(clk_sys), .rst_ni(reset_n), .sync_i(VSync), .sync_r_o(vs_r), .pol_o(vs_pol));

   assign hs_n    = hs_r ^ hs_pol;
   assign vs_n    = vs_r ^ vs_pol;
   assign hs_fall = hs_n_q & ~hs_n;
   assign vs_fall = vs_n_q & ~vs_n;

   // Parity is taken from its next-state value so the dimming flips on the
   // same output clock as VGA_HS falls.
   always_comb begin
      div_d = hs_fall ? 3'd0 : div_q + 3'd1;
      par_d = par_q;
      if (hs_fall) par_d = ~par_q;
      if (vs_fall) par_d = 1'b0;
      case (ce_div)
         2'd0:    mask = 3'd0;
         2'd1:    mask = 3'd1;
         2'd2:    mask = 3'd3;
         default: mask = 3'd7;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
         hs_n_q <= 1'b1;
         vs_n_q <= 1'b1;
         div_q  <= '0;
         par_q  <= 1'b0;
         ce_q   <= 1'b0;
         vr_q   <= '0;
         vg_q   <= '0;
         vb_q   <= '0;
         vhs_q  <= 1'b1;
         vvs_q  <= 1'b1;
      end else begin
         r_q    <= R;
         g_q    <= G;
         b_q    <= B;
         hs_n_q <= hs_n;
         vs_n_q <= vs_n;
         div_q  <= div_d;
         par_q  <= par_d;
         ce_q   <= ((div_q & mask) == 3'd0);
         vr_q   <= dim(expand(r_q), scanlines, par_d);
         vg_q   <= dim(expand(g_q), scanlines, par_d);
         vb_q   <= dim(expand(b_q), scanlines, par_d);
         vhs_q  <= csync_en ? (hs_n & vs_n) : hs_n;
         vvs_q  <= csync_en ? 1'b1 : vs_n;
      end
   end

   assign VGA_R  = vr_q;
   assign VGA_G  = vg_q;
   assign VGA_B  = vb_q;
   assign VGA_HS = vhs_q;
   assign VGA_VS = vvs_q;
   assign ce_pix = ce_q;
endmodule

// File: tb/tb_mist_video_out.sv
// Directed bench for mist_video_out: reset, latency, polarity detection,
// CE divider, colour expansion, scanlines, parity reset and composite sync.
module tb_mist_video_out;
   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic [1:0] ce_div, scanlines;
   logic       csync_en, HSync, VSync;
   logic [5:0] R, G, B;

   logic [5:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_HS, VGA_VS, ce_pix, hs_pol, vs_pol;
   logic [5:0] r4, g4, b4, r1, g1, b1;
   logic       hs4, vs4, ce4, hp4, vp4, hs1, vs1, ce1, hp1, vp1;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk_sys = ~clk_sys;

   mist_video_out dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce_div(ce_div), .scanlines(scanlines),
      .csync_en(csync_en), .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .ce_pix(ce_pix), .hs_pol(hs_pol), .vs_pol(vs_pol));

   mist_video_out #(.IN_DEPTH(4), .OUT_DEPTH(6)) dut4 (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce_div(ce_div), .scanlines(scanlines),
      .csync_en(csync_en), .R(R[3:0]), .G(G[3:0]), .B(B[3:0]), .HSync(HSync), .VSync(VSync),
      .VGA_R(r4), .VGA_G(g4), .VGA_B(b4), .VGA_HS(hs4), .VGA_VS(vs4),
      .ce_pix(ce4), .hs_pol(hp4), .vs_pol(vp4));

   mist_video_out #(.IN_DEPTH(1), .OUT_DEPTH(6)) dut1 (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce_div(ce_div), .scanlines(scanlines),
      .csync_en(csync_en), .R(R[0]), .G(G[0]), .B(B[0]), .HSync(HSync), .VSync(VSync),
      .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1),
      .ce_pix(ce1), .hs_pol(hp1), .vs_pol(vp1));

   task automatic clk1(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Sync pulse of level lvl for plen clocks, then the opposite level for rest.
   task automatic hline(input logic lvl, input int plen, input int rest);
      HSync = lvl;
      clk1(plen);
      HSync = ~lvl;
      clk1(rest);
   endtask

   initial begin
      // reset held with active inputs
      reset_n = 1'b0; ce_div = 2'd0; scanlines = 2'b00; csync_en = 1'b0;
      HSync = 1'b0; VSync = 1'b0; R = 6'h3f; G = 6'h3f; B = 6'h3f;
      clk1(4);
      chk("rst_vga_r", VGA_R, 6'h00);
      chk("rst_vga_b", VGA_B, 6'h00);
      chk("rst_hs", VGA_HS, 1'b1);
      chk("rst_vs", VGA_VS, 1'b1);
      chk("rst_ce", ce_pix, 1'b0);
      chk("rst_hpol", hs_pol, 1'b0);
      HSync = 1'b1; VSync = 1'b1; R = 6'd0; G = 6'd0; B = 6'd0;
      clk1(2);
      reset_n = 1'b1;
      clk1(3);
      chk("idle_r", VGA_R, 6'h00);
      chk("idle_hs", VGA_HS, 1'b1);

      // two-clock latency
      R = 6'd40; G = 6'd3; B = 6'd63;
      clk1(1);
      chk("lat1_r", VGA_R, 6'h00);
      clk1(1);
      chk("lat2_r", VGA_R, 6'd40);
      chk("ce_div0", ce_pix, 1'b1);

      // active-high HS, 100 high / 900 low
      ce_div = 2'd2; scanlines = 2'b10;
      hline(1'b1, 100, 900);
      hline(1'b1, 100, 900);
      chk("hpol_first_edge", hs_pol, 1'b0);
      hline(1'b1, 100, 900);
      chk("hpol_high", hs_pol, 1'b1);
      // odd line: HS, ce_pix and dimming all aligned to line start
      HSync = 1'b1;
      clk1(1);
      chk("l4_hs_p1", VGA_HS, 1'b1);
      chk("l4_r_even", VGA_R, 6'd40);
      clk1(1);
      chk("l4_hs_p2", VGA_HS, 1'b0);
      chk("l4_r_odd50", VGA_R, 6'd20);
      clk1(1);
      chk("ce4_p3", ce_pix, 1'b1);
      clk1(1);
      chk("ce4_p4", ce_pix, 1'b0);
      clk1(3);
      chk("ce4_p7", ce_pix, 1'b1);
      clk1(93);
      chk("l4_hs_p100", VGA_HS, 1'b0);
      HSync = 1'b0;
      clk1(1);
      chk("l4_hs_p101", VGA_HS, 1'b0);
      clk1(1);
      chk("l4_hs_p102", VGA_HS, 1'b1);
      clk1(898);

      // 25% dimming on the next odd line
      scanlines = 2'b01;
      hline(1'b1, 100, 900);
      HSync = 1'b1;
      clk1(2);
      chk("sl25_r", VGA_R, 6'd30);
      chk("sl25_b", VGA_B, 6'd48);
      clk1(98); HSync = 1'b0; clk1(900);

      // 75% dimming: 3 -> 0, 63 -> 15
      scanlines = 2'b11; R = 6'd3; G = 6'd3;
      hline(1'b1, 100, 900);
      HSync = 1'b1;
      clk1(1);
      chk("sl75_even_r", VGA_R, 6'd3);
      clk1(1);
      chk("sl75_r", VGA_R, 6'd0);
      chk("sl75_g", VGA_G, 6'd0);
      chk("sl75_b", VGA_B, 6'd15);
      clk1(98); HSync = 1'b0;

      // colour expansion, no dimming
      scanlines = 2'b00; R = 6'b001011;
      clk1(2);
      chk("exp66_r", VGA_R, 6'h0b);
      chk("exp46_r", r4, 6'b101110);
      chk("exp46_g", g4, 6'b001100);
      chk("exp46_b", b4, 6'h3f);
      chk("exp16_r", r1, 6'h3f);
      chk("exp16_g", g1, 6'h3f);
      chk("exp16_b", b1, 6'h3f);
      chk("exp46_hs", hs4, 1'b1);
      chk("exp16_vs", vs1, 1'b1);
      chk("exp_hp", {hp4, hp1, vp4, vp1, ce4, ce1}, 6'b110000);
      clk1(898);

      // /8 divider
      ce_div = 2'd3;
      HSync = 1'b1;
      clk1(2);
      for (int k = 3; k <= 11; k++) begin
         clk1(1);
         chk($sformatf("ce8_p%0d", k), ce_pix, (k == 3 || k == 11));
      end
      clk1(89); HSync = 1'b0; clk1(900);
      chk("hpol_hold", hs_pol, 1'b1);

      // inverted stimulus: low 100 / high 900
      hline(1'b0, 100, 900);
      hline(1'b0, 100, 900);
      chk("hpol_low", hs_pol, 1'b0);
      HSync = 1'b0;
      clk1(1);
      chk("inv_hs_p1", VGA_HS, 1'b1);
      clk1(1);
      chk("inv_hs_p2", VGA_HS, 1'b0);
      clk1(98);
      chk("inv_hs_p100", VGA_HS, 1'b0);
      HSync = 1'b1;
      clk1(1);
      chk("inv_hs_p101", VGA_HS, 1'b0);
      clk1(1);
      chk("inv_hs_p102", VGA_HS, 1'b1);
      clk1(898);

      // VS forces parity even, also when coinciding with HS
      scanlines = 2'b10; R = 6'd40;
      VSync = 1'b0; clk1(5); VSync = 1'b1; clk1(500);
      HSync = 1'b0; VSync = 1'b0;
      clk1(1);
      chk("vs_par_p1", VGA_R, 6'd40);
      clk1(1);
      chk("vs_par_p2", VGA_R, 6'd40);
      chk("vs_hs_low", VGA_HS, 1'b0);
      chk("vs_vs_low", VGA_VS, 1'b0);
      clk1(98); HSync = 1'b1; VSync = 1'b1; clk1(900);
      HSync = 1'b0;
      clk1(2);
      chk("vs_next_odd", VGA_R, 6'd20);

      // composite sync toggled mid-frame
      csync_en = 1'b1;
      clk1(1);
      chk("cs_hs_a", VGA_HS, 1'b0);
      chk("cs_vs_a", VGA_VS, 1'b1);
      HSync = 1'b1; VSync = 1'b0;
      clk1(2);
      chk("cs_hs_b", VGA_HS, 1'b0);
      chk("cs_vs_b", VGA_VS, 1'b1);
      csync_en = 1'b0;
      clk1(1);
      chk("sep_hs", VGA_HS, 1'b1);
      chk("sep_vs", VGA_VS, 1'b0);
      VSync = 1'b1;
      clk1(3);
      chk("sep_vs_rel", VGA_VS, 1'b1);
      chk("vpol_low", vs_pol, 1'b0);

      // reset mid-line clears outputs at once
      ce_div = 2'd0;
      clk1(3);
      chk("pre_rst_ce", ce_pix, 1'b1);
      HSync = 1'b0;
      clk1(1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_r", VGA_R, 6'h00);
      chk("mid_rst_hs", VGA_HS, 1'b1);
      chk("mid_rst_vs", VGA_VS, 1'b1);
      chk("mid_rst_ce", ce_pix, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
